// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like handshake bundle shared by the fetch port, the load/store
// port and the external memory bus.
interface sram_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_cancel;
   logic              inst_addr_ok;
   logic              inst_data_ok;
   logic [DATA_W-1:0] inst_rdata;

   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   logic              bus_req;
   logic              bus_wr;
   logic [1:0]        bus_size;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_addr_ok;
   logic              bus_data_ok;
   logic [DATA_W-1:0] bus_rdata;

   modport slave (
      input  inst_req, inst_addr, inst_cancel,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size,
      input  data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output bus_req, bus_wr, bus_size,
      output bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport master (
      output inst_req, inst_addr, inst_cancel,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size,
      output data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  bus_req, bus_wr, bus_size,
      input  bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Single-outstanding arbiter of fetch and load/store ports onto one SRAM
// bus; data-first priority with an instruction starvation guard.
module sram_bus_arbiter #(
   parameter int unsigned MAX_STARVE = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst,
   sram_bus_arbiter_if.slave   io,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DATA
   } state_t;

   localparam logic [3:0] MAX_S = 4'(MAX_STARVE);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              drop_q, drop_d;
   logic [3:0]        starve_q, starve_d;

   logic              grant_inst;
   logic              bus_req_c;
   logic              addr_ok_c;
   logic              data_ok_c;
   logic              inst_kill;

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         drop_q   <= 1'b0;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         drop_q   <= drop_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      drop_d     = drop_q;
      starve_d   = starve_q;
      grant_inst = 1'b0;
      bus_req_c  = 1'b0;
      addr_ok_c  = 1'b0;
      data_ok_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (io.data_req || io.inst_req) begin
               grant_inst = io.inst_req &&
                  (!io.data_req || starve_q == MAX_S);
               state_d = REQ;
               drop_d  = 1'b0;
               if (grant_inst) begin
                  owner_d  = 1'b0;
                  wr_d     = 1'b0;
                  size_d   = 2'd2;
                  addr_d   = io.inst_addr;
                  wdata_d  = '0;
                  starve_d = 4'd0;
               end else begin
                  owner_d = 1'b1;
                  wr_d    = io.data_wr;
                  size_d  = io.data_size;
                  addr_d  = io.data_addr;
                  wdata_d = io.data_wdata;
                  // Count only data grants that made a fetch wait
                  if (!io.inst_req)
                     starve_d = 4'd0;
                  else if (starve_q != MAX_S)
                     starve_d = starve_q + 4'd1;
               end
            end
         end
         REQ: begin
            bus_req_c = 1'b1;
            if (io.bus_addr_ok) begin
               addr_ok_c = 1'b1;
               if (io.bus_data_ok) begin
                  data_ok_c = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (io.bus_data_ok) begin
               data_ok_c = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A flushed fetch still runs on the bus; only its response is hidden
      if (state_q != IDLE && !owner_q && io.inst_cancel)
         drop_d = 1'b1;
   end

   assign inst_kill = drop_q || io.inst_cancel;

   assign io.bus_req   = bus_req_c;
   assign io.bus_wr    = wr_q;
   assign io.bus_size  = size_q;
   assign io.bus_addr  = addr_q;
   assign io.bus_wdata = wdata_q;

   assign io.inst_addr_ok = addr_ok_c && !owner_q && !inst_kill;
   assign io.inst_data_ok = data_ok_c && !owner_q && !inst_kill;
   assign io.data_addr_ok = addr_ok_c && owner_q;
   assign io.data_data_ok = data_ok_c && owner_q;

   assign io.inst_rdata = io.inst_data_ok ? io.bus_rdata : '0;
   assign io.data_rdata = io.data_data_ok ? io.bus_rdata : '0;

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scenario tasks plus a randomized run against a transaction-level
// reference of the arbitration, flush and handshake rules.
module tb_sram_bus_arbiter;

   localparam int MS = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   sram_bus_arbiter #(
      .MAX_STARVE(MS),
      .ADDR_W(32),
      .DATA_W(32)
   ) dut (
      .cpu_clk_50M(clk),
      .cpu_rst(rst),
      .io(bus_if),
      .busy(busy)
   );

   task automatic clr();
      bus_if.inst_req    = 1'b0;
      bus_if.inst_addr   = '0;
      bus_if.inst_cancel = 1'b0;
      bus_if.data_req    = 1'b0;
      bus_if.data_wr     = 1'b0;
      bus_if.data_size   = 2'd0;
      bus_if.data_addr   = '0;
      bus_if.data_wdata  = '0;
      bus_if.bus_addr_ok = 1'b0;
      bus_if.bus_data_ok = 1'b0;
      bus_if.bus_rdata   = '0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clr();
      rst = 1'b1;
      bus_if.inst_req    = 1'b1;
      bus_if.data_req    = 1'b1;
      bus_if.bus_addr_ok = 1'b1;
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'hFFFF_FFFF;
      #3;
      n_chk++;
      if ({busy, bus_if.bus_req, bus_if.inst_addr_ok,
           bus_if.inst_data_ok, bus_if.data_addr_ok,
           bus_if.data_data_ok} !== 6'b0)
         $display("FAIL reset_ctl: got %b want 000000",
            {busy, bus_if.bus_req, bus_if.inst_addr_ok,
             bus_if.inst_data_ok, bus_if.data_addr_ok,
             bus_if.data_data_ok});
      else n_pass++;
      n_chk++;
      if ({bus_if.inst_rdata, bus_if.data_rdata, bus_if.bus_addr,
           bus_if.bus_wdata} !== 128'h0)
         $display("FAIL reset_data: got %h want 0",
            {bus_if.inst_rdata, bus_if.data_rdata,
             bus_if.bus_addr, bus_if.bus_wdata});
      else n_pass++;
      do_reset();
   endtask

   task automatic test_lone_fetch();
      do_reset();
      bus_if.inst_req  = 1'b1;
      bus_if.inst_addr = 32'hBFC0_0000;
      #1;
      n_chk++;
      if ({busy, bus_if.bus_req} !== 2'b00)
         $display("FAIL lone_idle: got %b want 00", {busy, bus_if.bus_req});
      else n_pass++;
      step(); #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wr,
           bus_if.bus_size, bus_if.inst_addr_ok} !==
          {1'b1, 32'hBFC0_0000, 1'b0, 2'd2, 1'b0})
         $display("FAIL lone_req1: got %b/%h/%b/%0d/%b",
            bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wr,
            bus_if.bus_size, bus_if.inst_addr_ok);
      else n_pass++;
      step();
      bus_if.bus_addr_ok = 1'b1;
      #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.inst_addr_ok, bus_if.data_addr_ok,
           bus_if.bus_addr} !== {3'b110, 32'hBFC0_0000})
         $display("FAIL lone_addr_ok: got %b%b%b %h want 110 bfc00000",
            bus_if.bus_req, bus_if.inst_addr_ok,
            bus_if.data_addr_ok, bus_if.bus_addr);
      else n_pass++;
      step();
      bus_if.bus_addr_ok = 1'b0;
      bus_if.inst_req    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_chk++;
         if ({bus_if.bus_req, busy, bus_if.inst_addr_ok,
              bus_if.inst_data_ok} !== 4'b0100)
            $display("FAIL lone_wait%0d: got %b want 0100", i,
               {bus_if.bus_req, busy, bus_if.inst_addr_ok,
                bus_if.inst_data_ok});
         else n_pass++;
         step();
      end
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'h3C01_0000;
      #1;
      n_chk++;
      if ({bus_if.inst_data_ok, bus_if.data_data_ok, bus_if.inst_rdata}
          !== {2'b10, 32'h3C01_0000})
         $display("FAIL lone_data: got %b%b %h want 10 3c010000",
            bus_if.inst_data_ok, bus_if.data_data_ok, bus_if.inst_rdata);
      else n_pass++;
      step();
      bus_if.bus_data_ok = 1'b0;
      #1;
      n_chk++;
      if ({busy, bus_if.inst_data_ok, bus_if.inst_rdata} !== 34'h0)
         $display("FAIL lone_done: got %b%b %h want 00 0",
            busy, bus_if.inst_data_ok, bus_if.inst_rdata);
      else n_pass++;
   endtask

   task automatic test_data_first();
      do_reset();
      bus_if.data_req   = 1'b1;
      bus_if.data_wr    = 1'b1;
      bus_if.data_size  = 2'd0;
      bus_if.data_addr  = 32'h8000_1000;
      bus_if.data_wdata = 32'h1234_5678;
      bus_if.inst_req   = 1'b1;
      bus_if.inst_addr  = 32'hBFC0_0010;
      step();
      bus_if.bus_addr_ok = 1'b1;
      #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size,
           bus_if.bus_addr, bus_if.bus_wdata, bus_if.data_addr_ok,
           bus_if.inst_addr_ok} !==
          {2'b11, 2'd0, 32'h8000_1000, 32'h1234_5678, 2'b10})
         $display("FAIL both_grant: got %b%b %0d %h %h %b%b",
            bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size,
            bus_if.bus_addr, bus_if.bus_wdata,
            bus_if.data_addr_ok, bus_if.inst_addr_ok);
      else n_pass++;
      step();
      bus_if.data_req    = 1'b0;
      bus_if.bus_addr_ok = 1'b0;
      bus_if.bus_data_ok = 1'b1;
      #1;
      n_chk++;
      if ({bus_if.data_data_ok, bus_if.inst_data_ok} !== 2'b10)
         $display("FAIL both_store_done: got %b want 10",
            {bus_if.data_data_ok, bus_if.inst_data_ok});
      else n_pass++;
      step();
      bus_if.bus_data_ok = 1'b0;
      #1;
      n_chk++;
      if ({busy, bus_if.bus_req} !== 2'b00)
         $display("FAIL both_bubble: got %b want 00", {busy, bus_if.bus_req});
      else n_pass++;
      step(); #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wr,
           bus_if.bus_size} !== {1'b1, 32'hBFC0_0010, 1'b0, 2'd2})
         $display("FAIL both_inst_grant: got %b %h %b %0d",
            bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wr,
            bus_if.bus_size);
      else n_pass++;
      bus_if.bus_addr_ok = 1'b1;
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'hAABB_CCDD;
      #1;
      n_chk++;
      if ({bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.inst_rdata}
          !== {2'b11, 32'hAABB_CCDD})
         $display("FAIL both_inst_done: got %b%b %h want 11 aabbccdd",
            bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.inst_rdata);
      else n_pass++;
      step();
      clr();
      #1;
      n_chk++;
      if (busy !== 1'b0)
         $display("FAIL both_idle: got %b want 0", busy);
      else n_pass++;
   endtask

   task automatic test_starvation();
      int  cnt;
      bit  exp_inst;
      do_reset();
      bus_if.data_req    = 1'b1;
      bus_if.data_addr   = 32'h8000_0040;
      bus_if.data_size   = 2'd2;
      bus_if.inst_req    = 1'b1;
      bus_if.inst_addr   = 32'hBFC0_0100;
      bus_if.bus_addr_ok = 1'b1;
      bus_if.bus_data_ok = 1'b1;
      cnt = 0;
      for (int g = 0; g < 2 * MS + 3; g++) begin
         exp_inst = (cnt == MS);
         cnt = exp_inst ? 0 : ((cnt < MS) ? cnt + 1 : MS);
         step(); #1;
         n_chk++;
         if ({bus_if.bus_req, bus_if.bus_addr[31:28],
              bus_if.inst_addr_ok, bus_if.data_addr_ok} !==
             {1'b1, exp_inst ? 4'hB : 4'h8, exp_inst, !exp_inst})
            $display("FAIL starve_g%0d: got %b %h %b%b want inst=%0d", g,
               bus_if.bus_req, bus_if.bus_addr, bus_if.inst_addr_ok,
               bus_if.data_addr_ok, exp_inst);
         else n_pass++;
         step();
      end
      clr();
   endtask

   task automatic test_flush();
      do_reset();
      bus_if.inst_req  = 1'b1;
      bus_if.inst_addr = 32'hBFC0_0200;
      step();
      bus_if.bus_addr_ok = 1'b1;
      #1;
      n_chk++;
      if (bus_if.inst_addr_ok !== 1'b1)
         $display("FAIL flush_addr_ok: got %b want 1", bus_if.inst_addr_ok);
      else n_pass++;
      step();
      bus_if.inst_req    = 1'b0;
      bus_if.bus_addr_ok = 1'b0;
      bus_if.inst_cancel = 1'b1;
      #1;
      n_chk++;
      if ({busy, bus_if.inst_data_ok} !== 2'b10)
         $display("FAIL flush_pulse: got %b want 10", {busy, bus_if.inst_data_ok});
      else n_pass++;
      step();
      bus_if.inst_cancel = 1'b0;
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'hDEAD_BEEF;
      #1;
      n_chk++;
      if ({bus_if.inst_data_ok, bus_if.inst_rdata} !== 33'h0)
         $display("FAIL flush_drop: got %b %h want 0 0",
            bus_if.inst_data_ok, bus_if.inst_rdata);
      else n_pass++;
      step();
      clr();
      #1;
      n_chk++;
      if (busy !== 1'b0)
         $display("FAIL flush_free: got %b want 0", busy);
      else n_pass++;
      bus_if.inst_req  = 1'b1;
      bus_if.inst_addr = 32'hBFC0_0380;
      step(); #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'hBFC0_0380})
         $display("FAIL flush_refetch: got %b %h want 1 bfc00380",
            bus_if.bus_req, bus_if.bus_addr);
      else n_pass++;
      bus_if.bus_addr_ok = 1'b1;
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'h2408_0001;
      #1;
      n_chk++;
      if ({bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.inst_rdata}
          !== {2'b11, 32'h2408_0001})
         $display("FAIL flush_refetch_done: got %b%b %h want 11 24080001",
            bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.inst_rdata);
      else n_pass++;
      step();
      clr();
   endtask

   task automatic test_same_cycle();
      do_reset();
      bus_if.data_req  = 1'b1;
      bus_if.data_size = 2'd1;
      bus_if.data_addr = 32'h8000_2002;
      step(); #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size} !== 4'b1001)
         $display("FAIL same_req: got %b want 1001",
            {bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size});
      else n_pass++;
      bus_if.bus_addr_ok = 1'b1;
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'h0000_BEEF;
      #1;
      n_chk++;
      if ({bus_if.data_addr_ok, bus_if.data_data_ok, bus_if.inst_addr_ok,
           bus_if.inst_data_ok, bus_if.data_rdata} !==
          {4'b1100, 32'h0000_BEEF})
         $display("FAIL same_ok: got %b%b%b%b %h want 1100 0000beef",
            bus_if.data_addr_ok, bus_if.data_data_ok,
            bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.data_rdata);
      else n_pass++;
      step();
      clr();
      #1;
      n_chk++;
      if ({busy, bus_if.bus_req} !== 2'b00)
         $display("FAIL same_idle: got %b want 00", {busy, bus_if.bus_req});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus_if.data_req   = 1'b1;
      bus_if.data_wr    = 1'b1;
      bus_if.data_addr  = 32'h8000_3000;
      bus_if.data_wdata = 32'h0BAD_F00D;
      step();
      bus_if.bus_addr_ok = 1'b1;
      step();
      bus_if.data_req    = 1'b0;
      bus_if.bus_addr_ok = 1'b0;
      #1;
      n_chk++;
      if ({busy, bus_if.bus_req} !== 2'b10)
         $display("FAIL rstmid_data: got %b want 10", {busy, bus_if.bus_req});
      else n_pass++;
      #1;
      bus_if.bus_data_ok = 1'b1;
      bus_if.bus_rdata   = 32'h1111_2222;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({busy, bus_if.bus_req, bus_if.data_addr_ok, bus_if.data_data_ok,
           bus_if.inst_addr_ok, bus_if.inst_data_ok, bus_if.data_rdata}
          !== 38'h0)
         $display("FAIL rstmid_async: got %b %h want 0 0",
            {busy, bus_if.bus_req, bus_if.data_addr_ok,
             bus_if.data_data_ok, bus_if.inst_addr_ok,
             bus_if.inst_data_ok}, bus_if.data_rdata);
      else n_pass++;
      clr();
      step();
      rst = 1'b0;
      bus_if.data_req  = 1'b1;
      bus_if.data_addr = 32'h8000_4000;
      bus_if.data_size = 2'd2;
      step(); #1;
      n_chk++;
      if ({bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wr,
           bus_if.bus_wdata} !== {1'b1, 32'h8000_4000, 1'b0, 32'h0})
         $display("FAIL rstmid_regrant: got %b %h %b %h",
            bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wr,
            bus_if.bus_wdata);
      else n_pass++;
      bus_if.bus_addr_ok = 1'b1;
      bus_if.bus_data_ok = 1'b1;
      #1;
      n_chk++;
      if ({bus_if.data_addr_ok, bus_if.data_data_ok} !== 2'b11)
         $display("FAIL rstmid_done: got %b want 11",
            {bus_if.data_addr_ok, bus_if.data_data_ok});
      else n_pass++;
      step();
      clr();
   endtask

   task automatic test_random();
      // reference: one transaction at a time, phases free/addr/data
      int          phase;
      bit          own_d;
      bit          drop;
      int          starve;
      bit          m_wr;
      logic [1:0]  m_size;
      logic [31:0] m_addr, m_wdata;
      bit          ipend, dpend;
      logic [31:0] ia, da, dw;
      bit          dwr;
      logic [1:0]  dsz;
      bit          aok, dok, kill, e_iaok, e_idok, e_daok, e_ddok;
      bit          gi;
      logic [136:0] exp_v, got_v;
      do_reset();
      phase = 0; own_d = 0; drop = 0; starve = 0;
      m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0;
      ipend = 0; dpend = 0;
      ia = 0; da = 0; dw = 0; dwr = 0; dsz = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!ipend && $urandom_range(0, 2) == 0) begin
            ipend = 1;
            ia = {4'hB, 26'($urandom), 2'b00};
         end
         if (!dpend && $urandom_range(0, 1) == 0) begin
            dpend = 1;
            da  = {4'h8, 28'($urandom)};
            dw  = $urandom;
            dwr = 1'($urandom);
            dsz = 2'($urandom_range(0, 2));
         end
         bus_if.inst_req    = ipend;
         bus_if.inst_addr   = ia;
         bus_if.data_req    = dpend;
         bus_if.data_addr   = da;
         bus_if.data_wdata  = dw;
         bus_if.data_wr     = dwr;
         bus_if.data_size   = dsz;
         bus_if.inst_cancel = ($urandom_range(0, 5) == 0);
         bus_if.bus_addr_ok = ($urandom_range(0, 2) != 0);
         bus_if.bus_data_ok = ($urandom_range(0, 4) < 2);
         bus_if.bus_rdata   = $urandom;
         #1;
         aok  = (phase == 1) && bus_if.bus_addr_ok;
         dok  = (aok && bus_if.bus_data_ok) ||
                (phase == 2 && bus_if.bus_data_ok);
         kill = drop || bus_if.inst_cancel;
         e_iaok = aok && !own_d && !kill;
         e_idok = dok && !own_d && !kill;
         e_daok = aok && own_d;
         e_ddok = dok && own_d;
         exp_v = {phase != 0, phase == 1, m_wr, m_size, m_addr, m_wdata,
                  e_iaok, e_idok, e_idok ? bus_if.bus_rdata : 32'h0,
                  e_daok, e_ddok, e_ddok ? bus_if.bus_rdata : 32'h0};
         got_v = {busy, bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size,
                  bus_if.bus_addr, bus_if.bus_wdata,
                  bus_if.inst_addr_ok, bus_if.inst_data_ok,
                  bus_if.inst_rdata, bus_if.data_addr_ok,
                  bus_if.data_data_ok, bus_if.data_rdata};
         n_chk++;
         if (got_v !== exp_v)
            $display("FAIL rand_c%0d: got %h want %h", cyc, got_v, exp_v);
         else n_pass++;
         if (phase == 0) begin
            if (ipend || dpend) begin
               gi = ipend && (!dpend || starve == MS);
               own_d = !gi;
               drop = 0;
               phase = 1;
               if (gi) begin
                  starve = 0;
                  m_wr = 0; m_size = 2'd2; m_addr = ia; m_wdata = 0;
               end else begin
                  starve = ipend ? ((starve < MS) ? starve + 1 : MS) : 0;
                  m_wr = dwr; m_size = dsz; m_addr = da; m_wdata = dw;
               end
            end
         end else begin
            if (!own_d && bus_if.inst_cancel) drop = 1;
            if (dok) phase = 0;
            else if (aok) phase = 2;
         end
         if (e_iaok) ipend = 0;
         if (e_daok) dpend = 0;
         step();
      end
      clr();
      step();
   endtask

   initial begin
      clr();
      rst = 1'b1;
      test_reset();
      test_lone_fetch();
      test_data_first();
      test_starvation();
      test_flush();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory bus (req / addr_ok / data_ok handshake) between the instruction-fetch port and the data (load/store) port of the pipeline.
- Allows a single outstanding transaction at a time.
- Uses fixed data-first priority, with a starvation guard so instruction fetch cannot be locked out.
- Discards an instruction response that belongs to a fetch invalidated by a pipeline flush.
- Sits between the fetch/memory stages and the external bus interface.

Parameters:
- MAX_STARVE, 4: number of consecutive data grants made while inst_req is pending; after that many, the next grant goes to instruction. Legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_cancel  in  1  flush pulse; the in-flight fetch response must be dropped.
- inst_addr_ok  out  1  fetch address accepted.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request; held with its fields until data_addr_ok.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  load data valid / store complete.
- data_rdata  out  DATA_W  load data.
- bus_req  out  1  bus request.
- bus_wr  out  1  bus write.
- bus_size  out  2  bus size.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  bus address handshake.
- bus_data_ok  in  1  bus data handshake.
- bus_rdata  in  DATA_W  bus read data.
- busy  out  1  transaction in progress.

Behaviour:
- States: IDLE, REQ, DATA. Registers: owner (0 = inst, 1 = data), latched wr/size/addr/wdata, drop flag, starve counter.
- Reset (async, any state): state = IDLE, owner = 0, drop = 0, starve = 0, all latched fields = 0. All outputs are 0: bus_req, the *_addr_ok and *_data_ok signals, busy, and the rdata outputs.

IDLE:
- bus_req = 0.
- If data_req and inst_req are both high: grant inst when starve == MAX_STARVE, otherwise grant data.
- If only one request is high, grant it.
- Grant action: latch that port's fields (inst port gives wr = 0, size = 2, wdata = 0), set owner, clear drop, go to REQ.
- Starve counter:
  - Inst grant clears it to 0.
  - Data grant with inst_req high increments it, saturating at MAX_STARVE.
  - Data grant with inst_req low clears it.
- Latency: request sampled in cycle N gives bus_req = 1 in cycle N+1.

REQ:
- bus_req = 1; bus_* outputs are driven only from latched registers and are stable until bus_addr_ok.
- On bus_addr_ok, the owner's *_addr_ok = 1 combinationally in the same cycle. Exception: owner = inst with drop set, or with inst_cancel high this cycle, gives inst_addr_ok = 0.
- Next state: DATA. If bus_data_ok is also high in the same cycle, complete as in DATA and go directly to IDLE.

DATA:
- bus_req = 0.
- On bus_data_ok: the owner's *_data_ok = 1 and *_rdata = bus_rdata in the same cycle, then go to IDLE.
- Owner = inst with drop set, or with inst_cancel high this cycle, gives inst_data_ok = 0; the transaction still completes on the bus.

General rules:
- Non-owner ok outputs are always 0. rdata outputs are 0 unless the matching data_ok is 1.
- inst_cancel while owner = inst in REQ or DATA sets drop. The bus transaction is never aborted, because bus_req must stay high until bus_addr_ok.
- inst_cancel in IDLE, or while owner = data, has no effect.
- A drop-suppressed fetch still frees the bus. The fetch port re-issues its request afterwards and it re-arbitrates normally.
- A requester that drops its req before its addr_ok while not yet granted is ignored.
- busy = (state != IDLE).
- New grants occur only from IDLE, so there is one bubble cycle between back-to-back transactions.

Test Plan:
- Lone fetch: inst_req with addr 0xBFC00000; bus_addr_ok on the 2nd REQ cycle; bus_data_ok 3 cycles later with 0x3C010000 -> bus_req high cycle 1 to the bus_addr_ok cycle, bus_addr = 0xBFC00000, bus_wr = 0, bus_size = 2; inst_addr_ok and inst_data_ok one cycle each; inst_rdata = 0x3C010000; busy returns to 0.
- Both requesting: data store (addr 0x80001000, wdata 0x12345678, size 0) plus fetch -> data granted first with bus_wr = 1, bus_size = 0; fetch granted in the IDLE after data completes.
- Starvation, MAX_STARVE = 4: data_req and inst_req held continuously -> grant order D, D, D, D, I, D...; starve counter reads 4 at the I grant, then 0.
- Flush: inst_cancel pulsed while owner = inst in DATA -> inst_data_ok stays 0 when bus_data_ok arrives; state returns to IDLE; a subsequent fetch to 0xBFC00380 completes normally.
- Same-cycle handshake: bus_addr_ok and bus_data_ok both high in REQ -> owner gets addr_ok and data_ok in the same cycle; next state is IDLE.
- Reset mid-transaction: cpu_rst asserted in DATA -> asynchronously bus_req = 0, busy = 0, all ok signals 0; after release a new data_req is granted normally.
